// File: rtl/multiport_regfile.sv
// Multi-port integer register file with issue/writeback busy scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle writes onto the read ports.
module multiport_regfile #(
    parameter int XLEN = 32,
    parameter int NREGS = 32,
    parameter int NRD = 2,
    parameter int NWR = 2,
    parameter logic [XLEN-1:0] SP_INIT = 32'h0000_F000,
    parameter logic [XLEN-1:0] GP_INIT = 32'h1000_0000,
    localparam int AW = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic [NWR-1:0]      wr_en,
    input  logic [NWR*AW-1:0]   wr_addr,
    input  logic [NWR*XLEN-1:0] wr_data,
    input  logic                iss_en,
    input  logic [AW-1:0]       iss_addr,
    output logic [NREGS-1:0]    busy_vec
);

    logic [XLEN-1:0]  regs [NREGS];
    logic [NREGS-1:0] busy;
    logic [NREGS-1:0] busy_nxt;
    logic [NREGS-1:0] we_r;
    logic [XLEN-1:0]  wd_r [NREGS];

    // Resolve write ports per register; later ports override earlier ones.
    always_comb begin
        for (int r = 0; r < NREGS; r++) begin
            we_r[r] = 1'b0;
            wd_r[r] = '0;
            for (int j = 0; j < NWR; j++) begin
                if (r != 0 && wr_en[j] && wr_addr[j*AW +: AW] == AW'(r)) begin
                    we_r[r] = 1'b1;
                    wd_r[r] = wr_data[j*XLEN +: XLEN];
                end
            end
        end
    end

    // Issue takes precedence over writeback: a new producer is outstanding.
    always_comb begin
        for (int r = 0; r < NREGS; r++) begin
            busy_nxt[r] = busy[r];
            if (we_r[r])
                busy_nxt[r] = 1'b0;
            if (r != 0 && iss_en && iss_addr == AW'(r))
                busy_nxt[r] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int r = 0; r < NREGS; r++)
                regs[r] <= '0;
            regs[2] <= SP_INIT;
            regs[3] <= GP_INIT;
            busy    <= '0;
        end else begin
            for (int r = 1; r < NREGS; r++)
                if (we_r[r])
                    regs[r] <= wd_r[r];
            busy <= busy_nxt;
        end
    end

    always_comb begin
        for (int i = 0; i < NRD; i++) begin
            logic [AW-1:0] a;
            a = rd_addr[i*AW +: AW];
            rd_data[i*XLEN +: XLEN] = (a == '0) ? '0 : regs[a];
`ifdef REGFILE_BYPASS_EN
            if (we_r[a])
                rd_data[i*XLEN +: XLEN] = wd_r[a];
`endif
            rd_busy[i] = (a != '0) && busy[a];
        end
    end

    assign busy_vec = busy;

endmodule

// File: tb/tb_multiport_regfile.sv
// Self-checking bench for multiport_regfile: directed cases plus
// randomized traffic against a sequential reference model.
module tb_multiport_regfile;

    localparam logic [31:0] SP = 32'h0000_F000;
    localparam logic [31:0] GP = 32'h1000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic [1:0]  rd_busy;
    logic [1:0]  wr_en;
    logic [9:0]  wr_addr;
    logic [63:0] wr_data;
    logic        iss_en;
    logic [4:0]  iss_addr;
    logic [31:0] busy_vec;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_mem [32];
    bit          m_busy [32];

    always #5 clk = ~clk;

    multiport_regfile dut (
        .clk(clk), .rst(rst),
        .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .iss_en(iss_en), .iss_addr(iss_addr), .busy_vec(busy_vec)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < 32; r++) begin
            m_mem[r] = 32'h0;
            m_busy[r] = 1'b0;
        end
        m_mem[2] = SP;
        m_mem[3] = GP;
    endtask

    // Apply ports in order, then issue: gives highest-port-wins and set-wins.
    task automatic model_update();
        if (!rst) begin
            model_reset();
        end else begin
            for (int j = 0; j < 2; j++) begin
                int a;
                a = int'(wr_addr[j*5 +: 5]);
                if (wr_en[j] && a != 0) begin
                    m_mem[a] = wr_data[j*32 +: 32];
                    m_busy[a] = 1'b0;
                end
            end
            if (iss_en && iss_addr != 0)
                m_busy[iss_addr] = 1'b1;
        end
    endtask

    task automatic check_all(input string tag);
        logic [31:0] bv;
        for (int i = 0; i < 2; i++) begin
            int a;
            logic [31:0] e;
            a = int'(rd_addr[i*5 +: 5]);
            e = (a == 0) ? 32'h0 : m_mem[a];
`ifdef REGFILE_BYPASS_EN
            for (int j = 0; j < 2; j++)
                if (rst && a != 0 && wr_en[j] && int'(wr_addr[j*5 +: 5]) == a)
                    e = wr_data[j*32 +: 32];
`endif
            check($sformatf("%s_rd%0d", tag, i), rd_data[i*32 +: 32], e);
            check($sformatf("%s_rb%0d", tag, i), {31'h0, rd_busy[i]},
                  {31'h0, (a != 0) && m_busy[a]});
        end
        for (int r = 0; r < 32; r++)
            bv[r] = m_busy[r];
        check({tag, "_bv"}, busy_vec, bv);
    endtask

    task automatic idle();
        wr_en = 2'b00;
        iss_en = 1'b0;
    endtask

    task automatic tick(input string tag);
        @(negedge clk);
        check_all(tag);
        @(posedge clk);
        model_update();
        #1;
    endtask

    initial begin
        rst = 1'b0;
        rd_addr = '0;
        wr_addr = '0;
        wr_data = '0;
        iss_addr = '0;
        idle();
        @(posedge clk);
        model_update();
        #1;
        rst = 1'b1;

        // 1: reset values
        rd_addr = {5'd3, 5'd2};
        #1;
        check("t1_sp", rd_data[31:0], SP);
        check("t1_gp", rd_data[63:32], GP);
        check("t1_bv", busy_vec, 32'h0);
        rd_addr = {5'd5, 5'd5};
        #1;
        check("t1_r5", rd_data[31:0], 32'h0);

        // 2: write to r0 dropped
        wr_en = 2'b01;
        wr_addr = {5'd0, 5'd0};
        wr_data = {32'h0, 32'hDEAD_BEEF};
        rd_addr = {5'd0, 5'd0};
        tick("t2");
        idle();
        #1;
        check("t2_r0", rd_data[31:0], 32'h0);
        check("t2_bv0", {31'h0, busy_vec[0]}, 32'h0);

        // 3: conflict, port 1 wins
        wr_en = 2'b11;
        wr_addr = {5'd7, 5'd7};
        wr_data = {32'h22, 32'h11};
        tick("t3");
        idle();
        rd_addr = {5'd7, 5'd7};
        #1;
        check("t3_r7", rd_data[31:0], 32'h22);

        // 4: scoreboard set, set-wins, clear
        iss_en = 1'b1;
        iss_addr = 5'd9;
        tick("t4a");
        idle();
        rd_addr = {5'd0, 5'd9};
        #1;
        check("t4_bv9", {31'h0, busy_vec[9]}, 32'h1);
        check("t4_rb9", {31'h0, rd_busy[0]}, 32'h1);
        iss_en = 1'b1;
        iss_addr = 5'd9;
        wr_en = 2'b01;
        wr_addr = {5'd0, 5'd9};
        wr_data = {32'h0, 32'h99};
        tick("t4b");
        idle();
        #1;
        check("t4_setwin", {31'h0, busy_vec[9]}, 32'h1);
        wr_en = 2'b10;
        wr_addr = {5'd9, 5'd0};
        wr_data = {32'h9A, 32'h0};
        tick("t4c");
        idle();
        #1;
        check("t4_clr", {31'h0, busy_vec[9]}, 32'h0);
        check("t4_r9", rd_data[31:0], 32'h9A);

        // 5: write/read same cycle
        rd_addr = {5'd0, 5'd4};
        wr_en = 2'b01;
        wr_addr = {5'd0, 5'd4};
        wr_data = {32'h0, 32'h5A5A};
        #1;
`ifdef REGFILE_BYPASS_EN
        check("t5_same", rd_data[31:0], 32'h5A5A);
`else
        check("t5_same", rd_data[31:0], 32'h0);
`endif
        tick("t5");
        idle();
        #1;
        check("t5_next", rd_data[31:0], 32'h5A5A);

        // 6: reset overrides issue and write
        iss_en = 1'b1;
        iss_addr = 5'd6;
        tick("t6a");
        rst = 1'b0;
        iss_en = 1'b1;
        iss_addr = 5'd6;
        wr_en = 2'b01;
        wr_addr = {5'd0, 5'd6};
        wr_data = {32'h0, 32'h1};
        @(posedge clk);
        model_update();
        #1;
        rst = 1'b1;
        idle();
        rd_addr = {5'd2, 5'd6};
        #1;
        check("t6_r6", rd_data[31:0], 32'h0);
        check("t6_sp", rd_data[63:32], SP);
        check("t6_bv", busy_vec, 32'h0);

        // random traffic, addresses biased low to provoke conflicts
        for (int n = 0; n < 400; n++) begin
            rst = ($urandom_range(0, 59) != 0);
            wr_en = 2'($urandom);
            for (int j = 0; j < 2; j++) begin
                wr_addr[j*5 +: 5] = $urandom_range(0, 1) ? 5'($urandom_range(0, 7))
                                                         : 5'($urandom);
                wr_data[j*32 +: 32] = $urandom;
            end
            for (int i = 0; i < 2; i++)
                rd_addr[i*5 +: 5] = $urandom_range(0, 1) ? 5'($urandom_range(0, 7))
                                                         : 5'($urandom);
            iss_en = ($urandom_range(0, 2) != 0);
            iss_addr = $urandom_range(0, 1) ? 5'($urandom_range(0, 7)) : 5'($urandom);
            tick("rnd");
        end

        rst = 1'b1;
        idle();
        tick("end");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
